// File: rtl/axis_packetizer_pkg.sv
// Shared definitions for the AXI-Stream packetizer.
// Contents:
//   pkt_state_e - packetizer control state (waiting for a first length
//                 vs. forwarding samples).
package axis_packetizer_pkg;

  typedef enum logic {
    UNCONFIGURED = 1'b0,
    ACTIVE       = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_packetizer_if.sv
// AXI-Stream style handshake bundle used by the packetizer ports.
// Signals:
//   data  [DWIDTH] - payload
//   valid          - source has a word
//   ready          - sink can take a word
//   last           - end-of-packet marker
//   ok             - transfer happens this cycle (valid && ready)
// Modports:
//   Master_Full - drives data/valid/last, observes ready/ok
//   Slave_Full  - drives ready, observes data/valid/last/ok
interface Axis_If #(
  parameter int DWIDTH = 256
);

  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;
  logic              ok;

  assign ok = valid && ready;

  modport Master_Full (
    output data,
    output valid,
    output last,
    input  ready,
    input  ok
  );

  modport Slave_Full (
    input  data,
    input  valid,
    input  last,
    input  ok,
    output ready
  );

endinterface

// File: rtl/axis_packetizer_skid_buffer.sv
// Two-entry register slice (skid buffer) carrying data and last.
// The output stage registers every accepted word, so m_axis.valid rises
// the cycle after the input handshake. A second holding entry absorbs the
// one word that can arrive while the output is stalled, which lets
// in_ready be a pure register output.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   in_valid/in_ready  - upstream handshake (in_ready = slice not full)
//   in_data, in_last   - upstream word and its end-of-packet flag
//   m_axis             - registered downstream stream
module axis_skid_buffer #(
  parameter int DWIDTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  Axis_If.Master_Full       m_axis
);

  logic [DWIDTH-1:0] data_p1;
  logic              last_p1;
  logic              vld_p1;
  logic [DWIDTH-1:0] skid_data_p1;
  logic              skid_last_p1;
  logic              skid_vld_p1;
  logic              in_ok;
  logic              out_free;

  assign in_ready = !skid_vld_p1;
  assign in_ok    = in_valid && in_ready;
  // Output slot can take a new word when empty or being consumed now.
  assign out_free = !vld_p1 || m_axis.ok;

  // ---- stage p1: output register + skid entry ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1      <= '0;
      last_p1      <= 1'b0;
      vld_p1       <= 1'b0;
      skid_data_p1 <= '0;
      skid_last_p1 <= 1'b0;
      skid_vld_p1  <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_p1) begin
        // in_ready is low while the skid entry is occupied, so no new
        // word can arrive in the same cycle it drains.
        data_p1     <= skid_data_p1;
        last_p1     <= skid_last_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= in_ok;
        if (in_ok) begin
          data_p1 <= in_data;
          last_p1 <= in_last;
        end
      end
    end else if (in_ok) begin
      skid_data_p1 <= in_data;
      skid_last_p1 <= in_last;
      skid_vld_p1  <= 1'b1;
    end
  end

  assign m_axis.data  = data_p1;
  assign m_axis.last  = last_p1;
  assign m_axis.valid = vld_p1;

endmodule

// File: rtl/axis_packetizer.sv
// Cuts a continuous sample stream into packets of a programmable length.
// A length (minus one) written on config_in is held as pending and only
// becomes active at a packet boundary, so a packet never changes length
// part-way through. Upstream may also end a packet early with data_in.last.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   data_in    - sample stream in (last = early termination)
//   config_in  - packet length minus one (LEN_W bits); last is ignored
//   data_out   - packetized stream, last on the final word of each packet
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DWIDTH  = 256,
  parameter int MAX_LEN = 4096
) (
  input  logic        clk,
  input  logic        reset,
  Axis_If.Slave_Full  data_in,
  Axis_If.Slave_Full  config_in,
  Axis_If.Master_Full data_out
);

  localparam int LEN_W = $clog2(MAX_LEN);

  pkt_state_e       state_q;
  pkt_state_e       state_d;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] active_len_q;
  logic [LEN_W-1:0] pend_len_q;
  logic             pend_vld_q;

  logic             slice_ready;
  logic             word_last;
  logic             at_boundary;
  logic             have_pend;
  logic [LEN_W-1:0] next_len;
  logic             unused_cfg_last;

  assign unused_cfg_last = config_in.last;

  // Length 0 makes every word compare equal, giving 1-word packets.
  assign word_last   = (count_q == active_len_q) || data_in.last;
  // Boundary: idle between packets, or the last word of a packet is
  // being accepted right now.
  assign at_boundary = data_in.ok ? word_last : (count_q == '0);
  // A write landing on the boundary cycle is the newest value and wins
  // over anything already pending.
  assign have_pend   = config_in.ok || pend_vld_q;
  assign next_len    = config_in.ok ? config_in.data : pend_len_q;

  assign config_in.ready = !reset;

  always_comb begin
    state_d       = state_q;
    data_in.ready = 1'b0;
    case (state_q)
      UNCONFIGURED: begin
        if (config_in.ok) state_d = ACTIVE;
      end
      ACTIVE: begin
        data_in.ready = slice_ready;
      end
      default: state_d = UNCONFIGURED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= UNCONFIGURED;
    else       state_q <= state_d;
  end

  // ---- stage p0: word counter and length registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      active_len_q <= '0;
      pend_len_q   <= '0;
      pend_vld_q   <= 1'b0;
    end else if (state_q == UNCONFIGURED) begin
      if (config_in.ok) begin
        active_len_q <= config_in.data;
        pend_len_q   <= config_in.data;
        pend_vld_q   <= 1'b0;
        count_q      <= '0;
      end
    end else begin
      if (data_in.ok) count_q <= word_last ? '0 : count_q + LEN_W'(1);
      if (at_boundary && have_pend) begin
        active_len_q <= next_len;
        pend_vld_q   <= 1'b0;
      end else if (config_in.ok) begin
        pend_len_q <= config_in.data;
        pend_vld_q <= 1'b1;
      end
    end
  end

  // ---- stage p1: registered output slice ----
  axis_skid_buffer #(
    .DWIDTH(DWIDTH)
  ) u_slice (
    .clk     (clk),
    .reset   (reset),
    .in_valid(data_in.valid && (state_q == ACTIVE)),
    .in_data (data_in.data),
    .in_last (word_last),
    .in_ready(slice_ready),
    .m_axis  (data_out)
  );

endmodule
